// File: rtl/axi_rom_slave.sv
// axi_rom_slave: AXI4 read-only slave in front of a synchronous single-port ROM.
// The ROM has a 1-cycle read latency. FIXED, INCR and WRAP bursts are supported,
// with burst-level SLVERR. A 2-entry skid buffer allows full-throughput bursts.
// Optional build macro AXI_ROM_RANGE_CHECK_EN: any beat that falls outside the
// ROM window returns SLVERR. When the macro is undefined, the word index aliases
// modulo DEPTH.
module axi_rom_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    input  logic [ID_W-1:0]          ARID_S,
    input  logic [ADDR_W-1:0]        ARADDR_S,
    input  logic [LEN_W-1:0]         ARLEN_S,
    input  logic [2:0]               ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    output logic [ID_W-1:0]          RID_S,
    output logic [DATA_W-1:0]        RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     ROM_CS,
    output logic [$clog2(DEPTH)-1:0] ROM_A,
    input  logic [DATA_W-1:0]        ROM_DO
);
    localparam int LSB = $clog2(DATA_W / 8);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [2:0] LSB_SIZE = 3'(LSB);
`ifdef AXI_ROM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] ROM_END = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(DEPTH * (DATA_W / 8));
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                arready_q, arready_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    icnt_q, icnt_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_err_q, rd_err_d;
    logic                rd_last_q, rd_last_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   dat0_q, dat0_d, dat1_q, dat1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic                last0_q, last0_d, last1_q, last1_d;

    logic                ar_err, range_err, beat_err, issue, r_pop, rvalid;
    logic [ADDR_W-1:0]   size_mask, rel, incr, wrap_mask, addr_next;
    logic [AW-1:0]       rom_idx;
    logic [2:0]          occ;
    logic [1:0]          n;
    logic [DATA_W-1:0]   push_dat;

    // Decode the burst-level error conditions of the incoming AR request
    always_comb begin
        size_mask = (ADDR_W'(1) << ARSIZE_S) - ADDR_W'(1);
        ar_err = 1'b0;
        if (ARSIZE_S > LSB_SIZE) ar_err = 1'b1;
        if (ARBURST_S == 2'b11) ar_err = 1'b1;
        if (ARBURST_S == 2'b10) begin
            if (!(ARLEN_S == LEN_W'(1) || ARLEN_S == LEN_W'(3) ||
                  ARLEN_S == LEN_W'(7) || ARLEN_S == LEN_W'(15))) ar_err = 1'b1;
            if ((ARADDR_S & size_mask) != '0) ar_err = 1'b1;
        end
    end

    // Compute the current beat's word index, the next beat's address, and the range check
    always_comb begin
        rel       = addr_q - BASE_ADDR;
        rom_idx   = AW'(rel >> LSB);
        incr      = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
            default: addr_next = addr_q + incr;
        endcase
        range_err = 1'b0;
`ifdef AXI_ROM_RANGE_CHECK_EN
        range_err = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= ROM_END);
`endif
    end

    // Next-state logic for the burst FSM; issues one ROM read per cycle while buffer space allows
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        icnt_d  = icnt_q;
        issue   = 1'b0;
        rvalid  = (cnt_q != 2'd0);
        r_pop   = rvalid && RREADY_S;
        beat_err = err_q || range_err;
        // Occupancy counts the read in flight and credits a pop that happens in the same cycle,
        // which keeps bursts bubble-free without letting the buffer overflow.
        occ = 3'(cnt_q) + 3'(rd_vld_q) - 3'(r_pop);
        case (state_q)
            IDLE: begin
                if (ARVALID_S && arready_q) begin
                    id_d    = ARID_S;
                    addr_d  = ARADDR_S;
                    len_d   = ARLEN_S;
                    size_d  = ARSIZE_S;
                    burst_d = ARBURST_S;
                    err_d   = ar_err;
                    icnt_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (occ < 3'd2) begin
                    issue  = 1'b1;
                    addr_d = addr_next;
                    icnt_d = icnt_q + LEN_W'(1);
                    if (icnt_q == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (r_pop && last0_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
        rd_vld_d  = issue;
        rd_err_d  = beat_err;
        rd_last_d = (icnt_q == len_q);
    end

    // Two-entry skid buffer: pop from the head, then append the word returned by the ROM
    always_comb begin
        dat0_d  = dat0_q;
        dat1_d  = dat1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        push_dat = rd_err_q ? '0 : ROM_DO;
        n = cnt_q;
        if (r_pop) begin
            dat0_d  = dat1_q;
            err0_d  = err1_q;
            last0_d = last1_q;
            n = cnt_q - 2'd1;
        end
        if (rd_vld_q) begin
            if (n == 2'd0) begin
                dat0_d  = push_dat;
                err0_d  = rd_err_q;
                last0_d = rd_last_q;
            end else begin
                dat1_d  = push_dat;
                err1_d  = rd_err_q;
                last1_d = rd_last_q;
            end
            n = n + 2'd1;
        end
        cnt_d = n;
    end

    // State registers; the asynchronous reset abandons any burst in progress
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            icnt_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_last_q <= 1'b0;
            cnt_q     <= '0;
            dat0_q    <= '0;
            dat1_q    <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            last0_q   <= 1'b0;
            last1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            icnt_q    <= icnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_last_q <= rd_last_d;
            cnt_q     <= cnt_d;
            dat0_q    <= dat0_d;
            dat1_q    <= dat1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            last0_q   <= last0_d;
            last1_q   <= last1_d;
        end
    end

    assign ARREADY_S = arready_q;
    assign RVALID_S  = rvalid;
    assign RID_S     = id_q;
    assign RDATA_S   = dat0_q;
    assign RRESP_S   = err0_q ? 2'b10 : 2'b00;
    assign RLAST_S   = rvalid && last0_q;
    assign ROM_CS    = issue && !beat_err;
    assign ROM_A     = rom_idx;
endmodule

// File: doc/axi_rom_slave.md
Name: axi_rom_slave

Overview:
- Parametrised AXI4 read-only slave fronting a synchronous single-port ROM macro. 1-cycle read latency.
- Next-generation boot/instruction ROM port on the AXI interconnect.
- Adds FIXED/INCR/WRAP bursts, per-beat error responses, parametrised width/depth/ID, and a 2-entry output skid buffer for full-throughput bursts.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width; power of 2, 32..256
ID_W, 4, AXI ID width
LEN_W, 4, ARLEN width
DEPTH, 4096, ROM words; power of 2
BASE_ADDR, 0, byte base address of the ROM window

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARVALID_S  in  1  read address valid
ARREADY_S  out  1  read address ready
ARID_S  in  ID_W  transaction ID
ARADDR_S  in  ADDR_W  byte start address
ARLEN_S  in  LEN_W  beats-1
ARSIZE_S  in  3  log2 bytes per beat
ARBURST_S  in  2  00 FIXED, 01 INCR, 10 WRAP
RVALID_S  out  1  read data valid
RREADY_S  in  1  read data ready
RID_S  out  ID_W  returned ID
RDATA_S  out  DATA_W  read data
RRESP_S  out  2  00 OKAY, 10 SLVERR
RLAST_S  out  1  last beat
ROM_CS  out  1  ROM chip select; read on ACLK edge when high
ROM_A  out  $clog2(DEPTH)  ROM word index
ROM_DO  in  DATA_W  ROM data, valid the cycle after the CS edge

Behaviour:
- Reset (async, ARESETn low): ARREADY_S=0, RVALID_S=0, RLAST_S=0, RDATA_S=0, RID_S=0, RRESP_S=0, ROM_CS=0. Skid buffer is emptied, counters are cleared, FSM goes to IDLE. A reset mid-burst abandons the burst; no further beats are returned.
- FSM states:
  - IDLE: ARREADY_S=1. The AR handshake latches ID, address, LEN, SIZE, BURST and error flags, then moves to ISSUE.
  - ISSUE: ARREADY_S=0. One ROM read per cycle while the skid buffer has room (occupancy counted including the read in flight). After LEN+1 reads have issued, moves to DRAIN.
  - DRAIN: waits for the RLAST handshake, then returns to IDLE.
  - The next AR is accepted no earlier than the cycle after the RLAST handshake.
- Latency: AR handshake at edge T → ROM read at T+1 → RVALID_S=1 with beat 0 at T+2.
  - With RREADY_S held high, beats follow one per cycle with no bubbles.
- Stall rules:
  - While RVALID_S && !RREADY_S, RDATA_S, RID_S, RRESP_S and RLAST_S stay stable.
  - The ROM is never re-read for a beat already issued.
  - The skid buffer absorbs the in-flight word; the buffer never overflows.
- Address arithmetic: LSB = log2(DATA_W/8); ROM_A = (addr - BASE_ADDR)[LSB +: $clog2(DEPTH)]. Each beat returns the full word; the master selects narrow lanes.
  - INCR: addr += 1<<SIZE per beat.
  - FIXED: addr unchanged for every beat.
  - WRAP: container = (LEN+1)<<SIZE; addr wraps to the aligned container base when it reaches base+container.
- Burst-level SLVERR. Any of the following makes every beat return RRESP=10, RDATA=0, with no ROM_CS for those beats:
  - SIZE > LSB;
  - BURST=11;
  - WRAP with LEN not in {1,3,7,15};
  - WRAP with an unaligned start (addr not a multiple of 1<<SIZE).
  - Beat count and timing are unchanged; RLAST is still given on beat LEN.
- RLAST_S=1 exactly on beat LEN; LEN=0 gives a single beat with RLAST=1.
- RID_S equals the latched ARID for every beat.
- ROM_CS=1 only in cycles that issue a valid (non-error) read; ROM_A is don't-care otherwise.

Optional Feature:
- Macro: AXI_ROM_RANGE_CHECK_EN.
- Defined: a beat whose address is < BASE_ADDR or ≥ BASE_ADDR + DEPTH*(DATA_W/8) returns RRESP=10, RDATA=0, with no ROM_CS. Other beats of the same burst return OKAY.
- Undefined: no range check; the index aliases modulo DEPTH and RRESP=00.

Test Plan:
- Single read: ARADDR=0x10, LEN=0, SIZE=2, INCR, ARID=3; ROM[4]=0xDEADBEEF → RVALID two cycles after the AR handshake, RDATA=0xDEADBEEF, RLAST=1, RID=3, RRESP=00; ARREADY high again the next cycle.
- INCR burst with stalls: ARADDR=0x100, LEN=3, SIZE=2; RREADY toggled 1,0,0,1,1,0,1 → beats ROM[0x40..0x43] in order, each held stable while stalled; RLAST only on the 4th beat; ROM_CS pulses exactly 4 times.
- WRAP burst: ARADDR=0x18, LEN=3, SIZE=2, WRAP → word indices 6,7,4,5. With RREADY held high → 4 consecutive RVALID cycles.
- Errors:
  - SIZE=3 on DATA_W=32, LEN=1 → 2 beats, RRESP=10, RDATA=0, RLAST on beat 2, ROM_CS never asserted.
  - BURST=11 gives the same result.
  - WRAP with LEN=2 → SLVERR.
- Back-to-back: two LEN=1 bursts with ARVALID held → second AR accepted the cycle after the first RLAST handshake; IDs returned in order.
- Reset mid-burst: assert ARESETn=0 during beat 2 of LEN=7 → RVALID falls immediately. After release: ARREADY=1, and a new LEN=0 read returns the correct data.
- Range check (macro on, DEPTH=16, BASE=0): INCR LEN=1 at 0x3C → beat 0 OKAY, beat 1 (0x40) SLVERR with RDATA=0.
- Range check (macro off), same stimulus → beat 1 returns ROM[0] with OKAY.
